// File: rtl/spi_flash_regbank.sv
// RAXI register bank for the SPI flash controller: command registers, TX/RX byte FIFOs,
// start/done handshake with the SPI engine and sticky status/error reporting.
module spi_flash_regbank #(
   parameter int FIFO_DEPTH = 8,
   parameter int FIFO_AW    = 3
) (
   input  logic        S_ACLK,
   input  logic        S_ARESETN,
   input  logic        raxi_wvalid,
   input  logic        raxi_rvalid,
   input  logic [31:0] raxi_address,
   input  logic [31:0] raxi_wdata,
   output logic [31:0] raxi_rdata,
   output logic        raxi_ready,
   output logic        cmd_start,
   output logic [7:0]  cmd_opcode,
   output logic [31:0] cmd_addr,
   output logic [1:0]  cmd_addr_len,
   output logic [3:0]  cmd_dummy,
   output logic        cmd_write,
   output logic [8:0]  cmd_len,
   input  logic        cmd_done,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        irq
);

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   localparam logic [2:0] A_CTRL = 3'd0;
   localparam logic [2:0] A_ADDR = 3'd1;
   localparam logic [2:0] A_LEN  = 3'd2;
   localparam logic [2:0] A_GO   = 3'd3;
   localparam logic [2:0] A_STAT = 3'd4;
   localparam logic [2:0] A_TXD  = 3'd5;
   localparam logic [2:0] A_RXD  = 3'd6;
   localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW+1)'(FIFO_DEPTH);

   state_t state_q, state_d;
   logic       start_d, busy_err_set, done_set, go, busy;
   logic [2:0] sel;
   logic [15:0] ctrl_q;
   logic [31:0] addr_q;
   logic [8:0]  len_q, len_wr;
   logic ready_q, start_q, done_q, busy_err_q, tx_ovf_q, rx_ovf_q, rx_unf_q;
   logic wr_ctrl, wr_addr, wr_len, wr_stat;

   logic [7:0]         tx_mem [FIFO_DEPTH];
   logic [FIFO_AW-1:0] tx_wptr, tx_rptr;
   logic [FIFO_AW:0]   tx_level;
   logic               tx_full, tx_empty, tx_push, tx_push_ok, tx_pop;

   logic [7:0]         rx_mem [FIFO_DEPTH];
   logic [FIFO_AW-1:0] rx_wptr, rx_rptr;
   logic [FIFO_AW:0]   rx_level;
   logic               rx_full, rx_empty, rx_rd, rx_pop, rx_push_ok;

   logic [31:0] status;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^{raxi_address[31:5], raxi_address[1:0]};
   assign sel  = raxi_address[4:2];
   assign busy = (state_q == ST_BUSY);

   // CTRL/ADDR/LEN are frozen while a command is in flight
   assign wr_ctrl = raxi_wvalid && (sel == A_CTRL) && !busy;
   assign wr_addr = raxi_wvalid && (sel == A_ADDR) && !busy;
   assign wr_len  = raxi_wvalid && (sel == A_LEN)  && !busy;
   assign wr_stat = raxi_wvalid && (sel == A_STAT);
   assign go      = raxi_wvalid && (sel == A_GO) && raxi_wdata[0];
   assign len_wr  = (raxi_wdata > 32'd256) ? 9'd256 : raxi_wdata[8:0];

   assign tx_full    = (tx_level == FULL_LVL);
   assign tx_empty   = (tx_level == '0);
   assign tx_push    = raxi_wvalid && (sel == A_TXD);
   assign tx_push_ok = tx_push && !tx_full;
   assign tx_pop     = !tx_empty && tx_ready;

   // fullness is judged before the same-cycle pop, so a full FIFO drops the engine byte
   assign rx_full    = (rx_level == FULL_LVL);
   assign rx_empty   = (rx_level == '0);
   assign rx_rd      = raxi_rvalid && (sel == A_RXD);
   assign rx_pop     = rx_rd && !rx_empty;
   assign rx_push_ok = rx_valid && !rx_full;

   always_comb begin
      state_d      = state_q;
      start_d      = 1'b0;
      busy_err_set = 1'b0;
      done_set     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (go) begin
               state_d = ST_BUSY;
               start_d = 1'b1;
            end
         end
         ST_BUSY: begin
            if (go) busy_err_set = 1'b1;
            if (cmd_done) begin
               state_d  = ST_IDLE;
               done_set = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge S_ACLK or negedge S_ARESETN) begin
      if (!S_ARESETN) begin
         state_q <= ST_IDLE;
         start_q <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         ready_q <= 1'b1;
      end
   end

   always_ff @(posedge S_ACLK or negedge S_ARESETN) begin
      if (!S_ARESETN) begin
         ctrl_q <= '0;
         addr_q <= '0;
         len_q  <= '0;
      end else begin
         if (wr_ctrl) ctrl_q <= raxi_wdata[15:0];
         if (wr_addr) addr_q <= raxi_wdata;
         if (wr_len)  len_q  <= len_wr;
      end
   end

   // sticky bits: the set is applied after the W1C clear so a same-cycle set wins
   always_ff @(posedge S_ACLK or negedge S_ARESETN) begin
      if (!S_ARESETN) begin
         done_q     <= 1'b0;
         busy_err_q <= 1'b0;
         tx_ovf_q   <= 1'b0;
         rx_ovf_q   <= 1'b0;
         rx_unf_q   <= 1'b0;
      end else begin
         if ((wr_stat && raxi_wdata[9]) || start_d) done_q <= 1'b0;
         if (wr_stat && raxi_wdata[8]) busy_err_q <= 1'b0;
         if (wr_stat && raxi_wdata[7]) rx_unf_q   <= 1'b0;
         if (wr_stat && raxi_wdata[6]) rx_ovf_q   <= 1'b0;
         if (wr_stat && raxi_wdata[5]) tx_ovf_q   <= 1'b0;
         if (done_set)               done_q     <= 1'b1;
         if (busy_err_set)           busy_err_q <= 1'b1;
         if (rx_rd && rx_empty)      rx_unf_q   <= 1'b1;
         if (rx_valid && rx_full)    rx_ovf_q   <= 1'b1;
         if (tx_push && tx_full)     tx_ovf_q   <= 1'b1;
      end
   end

   always_ff @(posedge S_ACLK or negedge S_ARESETN) begin
      if (!S_ARESETN) begin
         tx_wptr  <= '0;
         tx_rptr  <= '0;
         tx_level <= '0;
         rx_wptr  <= '0;
         rx_rptr  <= '0;
         rx_level <= '0;
      end else begin
         if (tx_push_ok) tx_wptr <= tx_wptr + FIFO_AW'(1);
         if (tx_pop)     tx_rptr <= tx_rptr + FIFO_AW'(1);
         if (tx_push_ok && !tx_pop)      tx_level <= tx_level + (FIFO_AW+1)'(1);
         else if (!tx_push_ok && tx_pop) tx_level <= tx_level - (FIFO_AW+1)'(1);
         if (rx_push_ok) rx_wptr <= rx_wptr + FIFO_AW'(1);
         if (rx_pop)     rx_rptr <= rx_rptr + FIFO_AW'(1);
         if (rx_push_ok && !rx_pop)      rx_level <= rx_level + (FIFO_AW+1)'(1);
         else if (!rx_push_ok && rx_pop) rx_level <= rx_level - (FIFO_AW+1)'(1);
      end
   end

   always_ff @(posedge S_ACLK) begin
      if (tx_push_ok) tx_mem[tx_wptr] <= raxi_wdata[7:0];
      if (rx_push_ok) rx_mem[rx_wptr] <= rx_data;
   end

   function automatic logic [3:0] sat4(input logic [FIFO_AW:0] lvl);
      if (32'(lvl) > 32'd15) return 4'd15;
      return 4'(lvl);
   endfunction

   assign status = {12'd0, sat4(rx_level), sat4(tx_level), 2'b00, done_q, busy_err_q,
                    rx_unf_q, rx_ovf_q, tx_ovf_q, rx_full, rx_empty, tx_full, tx_empty, busy};

   always_comb begin
      raxi_rdata = '0;
      unique case (sel)
         A_CTRL:  raxi_rdata = {16'd0, ctrl_q};
         A_ADDR:  raxi_rdata = addr_q;
         A_LEN:   raxi_rdata = {23'd0, len_q};
         A_STAT:  raxi_rdata = status;
         A_RXD:   if (!rx_empty) raxi_rdata = {23'd0, 1'b1, rx_mem[rx_rptr]};
         default: raxi_rdata = '0;
      endcase
   end

   assign raxi_ready   = ready_q;
   assign cmd_start    = start_q;
   assign cmd_opcode   = ctrl_q[7:0];
   assign cmd_addr_len = ctrl_q[9:8];
   assign cmd_dummy    = ctrl_q[13:10];
   assign cmd_write    = ctrl_q[14];
   assign cmd_addr     = addr_q;
   assign cmd_len      = len_q;
   assign tx_valid     = !tx_empty;
   assign tx_data      = tx_mem[tx_rptr];
   assign irq          = done_q & ctrl_q[15];

endmodule

// File: tb/tb_spi_flash_regbank.sv
// Scoreboard bench for spi_flash_regbank: stimulus queues expectations, one negedge
// monitor compares read data, probed status pins, command launches and TX drain bytes.
module tb_spi_flash_regbank;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        raxi_wvalid, raxi_rvalid;
   logic [31:0] raxi_address, raxi_wdata, raxi_rdata;
   logic        raxi_ready, cmd_start, cmd_write, cmd_done;
   logic [7:0]  cmd_opcode, tx_data, rx_data;
   logic [31:0] cmd_addr;
   logic [1:0]  cmd_addr_len;
   logic [3:0]  cmd_dummy;
   logic [8:0]  cmd_len;
   logic        tx_valid, tx_ready, rx_valid, irq;

   typedef struct {
      string       name;
      bit          is_sig;
      logic [31:0] exp;
   } rd_exp_t;

   rd_exp_t     rd_q[$];
   logic [55:0] start_q[$];
   logic [7:0]  tx_q[$];
   int          checks = 0;
   int          errors = 0;
   bit          end_req = 1'b0;
   bit          end_ack = 1'b0;

   spi_flash_regbank #(.FIFO_DEPTH(8), .FIFO_AW(3)) dut (
      .S_ACLK(clk), .S_ARESETN(rst_n),
      .raxi_wvalid(raxi_wvalid), .raxi_rvalid(raxi_rvalid),
      .raxi_address(raxi_address), .raxi_wdata(raxi_wdata),
      .raxi_rdata(raxi_rdata), .raxi_ready(raxi_ready),
      .cmd_start(cmd_start), .cmd_opcode(cmd_opcode), .cmd_addr(cmd_addr),
      .cmd_addr_len(cmd_addr_len), .cmd_dummy(cmd_dummy), .cmd_write(cmd_write),
      .cmd_len(cmd_len), .cmd_done(cmd_done),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (raxi_rvalid) begin
         if (rd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_read: actual=0x%08h required=none", raxi_rdata);
         end else begin
            rd_exp_t e;
            e = rd_q.pop_front();
            if (e.is_sig) cmp(e.name, {60'd0, irq, tx_valid, raxi_ready, cmd_start}, {32'd0, e.exp});
            else          cmp(e.name, {32'd0, raxi_rdata}, {32'd0, e.exp});
         end
      end
      if (cmd_start) begin
         if (start_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_cmd_start: actual=1 required=0");
         end else begin
            cmp("cmd_fields", {8'd0, cmd_write, cmd_addr_len, cmd_dummy, cmd_opcode, cmd_len, cmd_addr},
                {8'd0, start_q.pop_front()});
         end
      end
      if (tx_valid && tx_ready) begin
         if (tx_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_tx_byte: actual=0x%02h required=none", tx_data);
         end else begin
            cmp("tx_byte", {56'd0, tx_data}, {56'd0, tx_q.pop_front()});
         end
      end
      if (end_req && !end_ack) begin
         cmp("rd_queue_drained", 64'(rd_q.size()), 64'd0);
         cmp("start_queue_drained", 64'(start_q.size()), 64'd0);
         cmp("tx_queue_drained", 64'(tx_q.size()), 64'd0);
         end_ack = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      raxi_wvalid = 1'b1; raxi_address = a; raxi_wdata = d;
      tick();
      raxi_wvalid = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
      rd_q.push_back('{name: nm, is_sig: 1'b0, exp: exp});
      raxi_rvalid = 1'b1; raxi_address = a;
      tick();
      raxi_rvalid = 1'b0;
   endtask

   // probe uses an unmapped address so the read strobe has no side effects
   task automatic probe(input logic [3:0] exp, input string nm);
      rd_q.push_back('{name: nm, is_sig: 1'b1, exp: {28'd0, exp}});
      raxi_rvalid = 1'b1; raxi_address = 32'h1C;
      tick();
      raxi_rvalid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      rst_n = 1'b0; raxi_wvalid = 1'b0; raxi_rvalid = 1'b0;
      raxi_address = '0; raxi_wdata = '0; cmd_done = 1'b0;
      tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
      repeat (3) tick();
      probe(4'b0000, "ready_in_reset");
      rst_n = 1'b1;
      tick();

      rd(32'h10, 32'h0000_000A, "status_reset");
      rd(32'h00, 32'h0, "ctrl_reset");
      probe(4'b0010, "ready_after_reset");
      rd(32'h0C, 32'h0, "go_reads_zero");
      rd(32'h1C, 32'h0, "unmapped_reads_zero");

      wr(32'h00, 32'h4003);      rd(32'h00, 32'h4003, "ctrl_rw");
      wr(32'h04, 32'h0012_3400); rd(32'h04, 32'h0012_3400, "addr_rw");
      wr(32'h08, 32'd4);         rd(32'h08, 32'd4, "len_rw");
      for (int i = 1; i <= 4; i++) wr(32'h14, 32'(8'h11 * i));
      rd(32'h10, 32'h0000_4008, "status_tx4");
      start_q.push_back({1'b1, 2'd0, 4'd0, 8'h03, 9'd4, 32'h0012_3400});
      wr(32'h0C, 32'h1);
      probe(4'b0111, "start_pulse_hi");
      probe(4'b0110, "start_pulse_lo");
      rd(32'h10, 32'h0000_4009, "status_busy");
      wr(32'h00, 32'h00FF);
      rd(32'h00, 32'h4003, "ctrl_frozen_busy");

      wr(32'h0C, 32'h1);
      probe(4'b0110, "no_second_start");
      rd(32'h10, 32'h0000_4109, "busy_err_set");
      wr(32'h10, 32'h100);
      rd(32'h10, 32'h0000_4009, "busy_err_w1c");
      cmd_done = 1'b1; tick(); cmd_done = 1'b0;
      rd(32'h10, 32'h0000_4208, "done_after_cmd_done");
      for (int i = 1; i <= 4; i++) tx_q.push_back(8'(8'h11 * i));
      tx_ready = 1'b1; repeat (4) tick(); tx_ready = 1'b0;
      rd(32'h10, 32'h0000_020A, "status_tx_drained");

      for (int i = 1; i <= 9; i++) wr(32'h14, 32'(i));
      rd(32'h10, 32'h0000_822C, "status_tx_full_ovf");
      wr(32'h10, 32'h220);
      rd(32'h10, 32'h0000_800C, "status_w1c_ovf_done");
      tx_q.push_back(8'h01);
      tx_ready = 1'b1; wr(32'h14, 32'hEE); tx_ready = 1'b0;
      rd(32'h10, 32'h0000_7028, "push_pop_at_full");
      tx_q.push_back(8'h02);
      tx_ready = 1'b1; wr(32'h14, 32'h77); tx_ready = 1'b0;
      rd(32'h10, 32'h0000_7028, "push_pop_level_same");
      for (int i = 3; i <= 8; i++) tx_q.push_back(8'(i));
      tx_q.push_back(8'h77);
      tx_ready = 1'b1; repeat (7) tick(); tx_ready = 1'b0;
      rd(32'h10, 32'h0000_002A, "status_tx_empty_after_drain");
      wr(32'h10, 32'h20);
      rd(32'h10, 32'h0000_000A, "tx_ovf_w1c");

      rx_valid = 1'b1; rx_data = 8'hA5; tick();
      rx_data = 8'h5A; tick(); rx_valid = 1'b0;
      rd(32'h18, 32'h0000_01A5, "rx_pop_1");
      rd(32'h18, 32'h0000_015A, "rx_pop_2");
      rd(32'h18, 32'h0, "rx_pop_empty");
      rd(32'h10, 32'h0000_008A, "rx_unf_set");
      wr(32'h10, 32'h80);
      rd(32'h10, 32'h0000_000A, "rx_unf_w1c");

      rx_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rx_data = 8'(8'h80 + i);
         tick();
      end
      rx_data = 8'hFF;
      rd(32'h10, 32'h0008_0012, "status_rx_full");
      rd(32'h18, 32'h0000_0180, "rx_push_pop_full");
      rx_valid = 1'b0;
      rd(32'h10, 32'h0007_0042, "rx_ovf_level7");
      for (int i = 1; i < 8; i++) rd(32'h18, 32'(9'h180 + i), "rx_drain");
      rd(32'h10, 32'h0000_004A, "rx_empty_after_drain");
      wr(32'h10, 32'h40);

      wr(32'h00, 32'h9600); rd(32'h00, 32'h9600, "ctrl_irq_en");
      wr(32'h08, 32'h1FF);  rd(32'h08, 32'h100, "len_clamp_1ff");
      wr(32'h08, 32'hFF);   rd(32'h08, 32'hFF, "len_ff");
      wr(32'h08, 32'h1_0000); rd(32'h08, 32'h100, "len_clamp_upper");
      start_q.push_back({1'b0, 2'd2, 4'd5, 8'h00, 9'h100, 32'h0012_3400});
      wr(32'h0C, 32'h1);
      probe(4'b0011, "start_irq_low");
      rd(32'h10, 32'h0000_000B, "status_busy2");
      cmd_done = 1'b1; wr(32'h10, 32'h200); cmd_done = 1'b0;
      probe(4'b1010, "irq_set_wins_w1c");
      rd(32'h10, 32'h0000_020A, "done_set_wins");
      wr(32'h10, 32'h200);
      probe(4'b0010, "irq_cleared");
      cmd_done = 1'b1; tick(); cmd_done = 1'b0;
      rd(32'h10, 32'h0000_000A, "done_idle_ignored");

      wr(32'h0C, 32'h1);
      #1 rst_n = 1'b0;
      probe(4'b0000, "reset_mid_cmd");
      tick();
      rst_n = 1'b1;
      tick();
      rd(32'h10, 32'h0000_000A, "status_after_reset2");
      rd(32'h00, 32'h0, "ctrl_after_reset2");
      rd(32'h08, 32'h0, "len_after_reset2");

      repeat (2) tick();
      end_req = 1'b1;
      wait (end_ack);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
